// File: rtl/berzerk_input_cond.sv
// rtl/berzerk_input_cond.sv - joystick debounce and coin pulse shaper for the berzerk core
// Optional autofire on the fire bit is built when AUTOFIRE_EN is defined.
module berzerk_input_cond #(
    parameter int TICK_DIV    = 40000,
    parameter int DB_MS       = 5,
    parameter int COIN_MS     = 50,
    parameter int COIN_GAP_MS = 100,
    parameter int AF_MS       = 50
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [8:0] joy_in,
    input  logic       hold,
    input  logic       autofire_on,
    output logic [7:0] joy_out,
    output logic       coin_out,
    output logic [1:0] coin_pending,
    output logic       coin_overflow
);
    localparam int              TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [7:0]      DB_LIM    = 8'(DB_MS);
    localparam logic [7:0]      COIN_LAST = 8'(COIN_MS - 1);
    localparam logic [7:0]      GAP_LAST  = 8'(COIN_GAP_MS - 1);
    localparam logic [7:0]      AF_LAST   = 8'(AF_MS - 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

    logic [8:0]    joy_s1;
    logic [8:0]    joy_s2;
    logic [8:0]    db_state;
    logic [7:0]    db_cnt [9];
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          coin_prev;
    logic          coin_req;
    logic          launch;
    logic          fire_bit;
    coin_state_t   coin_state;
    logic [7:0]    coin_timer;
    logic [1:0]    credit_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            joy_s1   <= '0;
            joy_s2   <= '0;
            tick_cnt <= '0;
        end else begin
            joy_s1   <= joy_in;
            joy_s2   <= joy_s1;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // A bit flips only on the tick after it has differed for DB_MS whole ticks.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            db_state <= '0;
            for (int i = 0; i < 9; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (joy_s2[i] == db_state[i]) begin
                    db_cnt[i] <= '0;
                end else if (tick) begin
                    if (db_cnt[i] == DB_LIM) begin
                        db_state[i] <= joy_s2[i];
                        db_cnt[i]   <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

`ifdef AUTOFIRE_EN
    logic       af_off;
    logic [7:0] af_cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_off <= 1'b0;
            af_cnt <= '0;
        end else if (!db_state[4] || !autofire_on) begin
            af_off <= 1'b0;
            af_cnt <= '0;
        end else if (tick) begin
            if (af_cnt == AF_LAST) begin
                af_off <= ~af_off;
                af_cnt <= '0;
            end else begin
                af_cnt <= af_cnt + 8'd1;
            end
        end
    end

    assign fire_bit = db_state[4] & ~(autofire_on & af_off);
`else
    logic unused_cfg;
    assign unused_cfg = ^{autofire_on, AF_LAST};
    assign fire_bit   = db_state[4];
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) joy_out <= '0;
        else          joy_out <= {db_state[6:5], fire_bit, db_state[3:0], db_state[8]};
    end

    // A request arriving while IDLE is launched directly, so it never touches the queue.
    assign coin_req = db_state[7] & ~coin_prev;
    assign launch   = (coin_state == IDLE) && !hold && ((credit_cnt != 2'd0) || coin_req);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            coin_prev     <= 1'b0;
            credit_cnt    <= '0;
            coin_overflow <= 1'b0;
            coin_state    <= IDLE;
            coin_timer    <= '0;
            coin_out      <= 1'b0;
        end else begin
            coin_prev     <= db_state[7];
            coin_overflow <= 1'b0;
            if (coin_req && !launch) begin
                if (credit_cnt == 2'd3) coin_overflow <= 1'b1;
                else                    credit_cnt    <= credit_cnt + 2'd1;
            end else if (!coin_req && launch) begin
                credit_cnt <= credit_cnt - 2'd1;
            end
            case (coin_state)
                IDLE: begin
                    coin_timer <= '0;
                    if (launch) begin
                        coin_state <= PULSE;
                        coin_out   <= 1'b1;
                    end
                end
                PULSE: if (tick) begin
                    if (coin_timer == COIN_LAST) begin
                        coin_state <= GAP;
                        coin_out   <= 1'b0;
                        coin_timer <= '0;
                    end else begin
                        coin_timer <= coin_timer + 8'd1;
                    end
                end
                GAP: if (tick) begin
                    if (coin_timer == GAP_LAST) coin_state <= IDLE;
                    else                        coin_timer <= coin_timer + 8'd1;
                end
                default: coin_state <= IDLE;
            endcase
        end
    end

    assign coin_pending = credit_cnt;
endmodule

// File: tb/tb_berzerk_input_cond.sv
// tb/tb_berzerk_input_cond.sv - self-checking bench for berzerk_input_cond
`timescale 1ns/1ps
module tb_berzerk_input_cond;
    localparam int TD = 40;
`ifdef AUTOFIRE_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic [8:0] joy_in = '0;
    logic       hold = 1'b0;
    logic       autofire_on = 1'b0;
    logic [7:0] joy_out;
    logic       coin_out;
    logic [1:0] coin_pending;
    logic       coin_overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    berzerk_input_cond #(
        .TICK_DIV(TD), .DB_MS(5), .COIN_MS(50), .COIN_GAP_MS(100), .AF_MS(50)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .joy_in(joy_in), .hold(hold),
        .autofire_on(autofire_on), .joy_out(joy_out), .coin_out(coin_out),
        .coin_pending(coin_pending), .coin_overflow(coin_overflow)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] in;
        int         wait_cyc;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[13];

    // monitor state for the coin burst
    int pulses, maxp, ovf, rise_t, fall_t, minw, maxw, minlow, first_rise;
    logic prevc;

    // time-based debounce model
    int   since[9];
    logic rawb[9];
    logic mdb[9];
    bit   known[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        joy_in = '0;
        hold = 1'b0;
        autofire_on = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(2);
    endtask

    function automatic int out_pos(input int b);
        return (b == 8) ? 0 : b + 1;
    endfunction

    task automatic model_settle();
        int d;
        for (int b = 0; b < 9; b++) begin
            d = cyc - since[b];
            if (d >= 250) begin
                mdb[b] = rawb[b];
                known[b] = 1'b1;
            end else if (d >= 195) begin
                known[b] = 1'b0;
            end
        end
    endtask

    initial begin
        int n, w, seen, dur;
        logic [8:0] nv;
        logic [7:0] expv, mask;

        // 1. reset with everything pressed, then release
        reset_n = 1'b0;
        joy_in = 9'h1FF;
        step(5);
        check("reset_joy_out", joy_out, 8'h00);
        check("reset_coin_out", coin_out, 1'b0);
        check("reset_pending", coin_pending, 2'd0);
        check("reset_overflow", coin_overflow, 1'b0);
        reset_n = 1'b1;
        n = 0;
        while (joy_out !== 8'hFF && n < 400) begin step(1); n++; end
        check_range("release_latency", n, 200, 250);
        n = 0;
        while (coin_out !== 1'b1 && n < 10) begin step(1); n++; end
        check_range("release_coin_start", n, 0, 3);
        w = 0;
        while (coin_out === 1'b1 && w < 3000) begin step(1); w++; end
        check_range("release_coin_width", w, 1960, 2001);
        seen = 0;
        for (int c = 0; c < 4500; c++) begin step(1); if (coin_out) seen++; end
        check("release_single_pulse", seen, 0);

        // 2. bounce on right
        do_reset();
        step(10);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            joy_in[0] = ~joy_in[0];
            for (int c = 0; c < 100; c++) begin step(1); if (joy_out[1]) seen++; end
        end
        check("bounce_no_change", seen, 0);
        joy_in[0] = 1'b1;
        n = 0;
        while (joy_out[1] !== 1'b1 && n < 400) begin step(1); n++; end
        check_range("bounce_settle", n, 200, 250);

        // table-driven level vectors
        tbl[0]  = '{9'h001, 300, 8'h02};
        tbl[1]  = '{9'h002, 300, 8'h04};
        tbl[2]  = '{9'h004, 300, 8'h08};
        tbl[3]  = '{9'h008, 300, 8'h10};
        tbl[4]  = '{9'h010, 300, 8'h20};
        tbl[5]  = '{9'h020, 300, 8'h40};
        tbl[6]  = '{9'h040, 300, 8'h80};
        tbl[7]  = '{9'h100, 300, 8'h01};
        tbl[8]  = '{9'h17F, 300, 8'hFF};
        tbl[9]  = '{9'h000, 150, 8'hFF};
        tbl[10] = '{9'h000, 150, 8'h00};
        tbl[11] = '{9'h005, 100, 8'h00};
        tbl[12] = '{9'h005, 200, 8'h0A};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            joy_in = tbl[i].in;
            step(tbl[i].wait_cyc);
            check($sformatf("vec%0d", i), joy_out, tbl[i].exp);
        end

        // randomized levels against the time-based model
        do_reset();
        step(10);
        for (int b = 0; b < 9; b++) begin
            since[b] = cyc; rawb[b] = 1'b0; mdb[b] = 1'b0; known[b] = 1'b1;
        end
        for (int s = 0; s < 30; s++) begin
            nv = 9'($urandom) & 9'h17F;
            dur = ($urandom_range(0, 1) == 1) ? $urandom_range(10, 150) : $urandom_range(260, 400);
            for (int b = 0; b < 9; b++) begin
                if (nv[b] != rawb[b]) begin
                    model_settle();
                    since[b] = cyc;
                    rawb[b] = nv[b];
                end
            end
            joy_in = nv;
            step(dur);
            model_settle();
            expv = '0;
            mask = '0;
            for (int b = 0; b < 9; b++) begin
                if (b != 7 && known[b]) begin
                    mask[out_pos(b)] = 1'b1;
                    expv[out_pos(b)] = mdb[b];
                end
            end
            check($sformatf("rand%0d", s), joy_out & mask, expv & mask);
        end

        // 3. coin burst
        do_reset();
        step(5);
        pulses = 0; maxp = 0; ovf = 0; rise_t = -1; fall_t = -1;
        minw = 99999; maxw = 0; minlow = 99999; first_rise = -1; prevc = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    joy_in[7] = 1'b1; step(300);
                    joy_in[7] = 1'b0; step(300);
                end
            end
            begin
                for (int c = 0; c < 24000; c++) begin
                    step(1);
                    if (coin_out && !prevc) begin
                        pulses++;
                        if (first_rise < 0) first_rise = c;
                        if (fall_t >= 0 && (c - fall_t) < minlow) minlow = c - fall_t;
                        rise_t = c;
                    end
                    if (!coin_out && prevc) begin
                        if ((c - rise_t) < minw) minw = c - rise_t;
                        if ((c - rise_t) > maxw) maxw = c - rise_t;
                        fall_t = c;
                    end
                    if (int'(coin_pending) > maxp) maxp = int'(coin_pending);
                    if (coin_overflow) ovf++;
                    prevc = coin_out;
                end
            end
        join
        check_range("burst_first_start", first_rise, 200, 250);
        check("burst_pulses", pulses, 4);
        check("burst_max_pending", maxp, 3);
        check("burst_overflow", ovf, 1);
        check_range("burst_min_width", minw, 1960, 2001);
        check_range("burst_max_width", maxw, 1960, 2001);
        check_range("burst_min_low", minlow, 4000, 4010);

        // 4. hold blocks launch
        do_reset();
        hold = 1'b1;
        seen = 0;
        for (int k = 0; k < 2; k++) begin
            joy_in[7] = 1'b1;
            for (int c = 0; c < 300; c++) begin step(1); if (coin_out) seen++; end
            joy_in[7] = 1'b0;
            for (int c = 0; c < 300; c++) begin step(1); if (coin_out) seen++; end
        end
        check("hold_no_pulse", seen, 0);
        check("hold_pending", coin_pending, 2'd2);
        hold = 1'b0;
        step(1);
        check("unhold_coin_out", coin_out, 1'b1);
        check("unhold_pending", coin_pending, 2'd1);

        // 5. asynchronous reset in the middle of a pulse
        step(20 * TD);
        check("midpulse_before", coin_out, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("midpulse_async_drop", coin_out, 1'b0);
        check("midpulse_queue_lost", coin_pending, 2'd0);
        step(2);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 100; c++) begin step(1); if (coin_out || coin_pending != 2'd0) seen++; end
        check("after_reset_idle", seen, 0);
        joy_in[7] = 1'b1;
        n = 0;
        while (coin_out !== 1'b1 && n < 400) begin step(1); n++; end
        check_range("after_reset_new_coin", n, 200, 250);

        // 6. fire held with autofire enabled
        do_reset();
        autofire_on = 1'b1;
        joy_in[4] = 1'b1;
        n = 0;
        while (joy_out[5] !== 1'b1 && n < 400) begin step(1); n++; end
        check_range("fire_press", n, 200, 250);
        for (int k = 0; k < 6; k++) begin
            step(1000);
            check($sformatf("fire_seg%0d", k), joy_out[5], AF_EN ? ((k % 2) == 0) : 1'b1);
            step(1000);
        end
        joy_in[4] = 1'b0;
        step(260);
        check("fire_release", joy_out[5], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
